branch_scanner: RTL

//  Bracket-matching engine for CBF/CBB. When the issue stage takes a conditional branch, this block walks

---
 rtl/branch_scanner_pkg.sv | 45 ++++
 rtl/branch_scanner_nest_counter.sv | 46 ++++
 rtl/branch_scanner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/branch_scanner_pkg.sv
// ---------------------------------------------------------------------------
// branch_scanner_pkg
//   Shared definitions for the bracket-matching scanner: scan FSM states,
//   scan direction encodings, the instruction op_code enum and the
//   ENABLE/DISABLE levels. It also provides helpers that pick the opening
//   and closing bracket for a given scan direction.
// ---------------------------------------------------------------------------
package branch_scanner_pkg;

   typedef enum logic [1:0] {
      SCAN_IDLE,
      SCAN_FETCH,
      SCAN_DONE,
      SCAN_ERROR
   } scan_state_e;

   localparam logic SCAN_FWD  = 1'b0;
   localparam logic SCAN_BACK = 1'b1;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [3:0] {
      NOP   = 4'h0,
      ADD   = 4'h1,
      SUB   = 4'h2,
      LEFT  = 4'h3,
      RIGHT = 4'h4,
      PUT   = 4'h5,
      GET   = 4'h6,
      CBF   = 4'h7,
      CBB   = 4'h8
   } op_code;

   // Bracket that deepens nesting when met in the given scan direction.
   function automatic op_code open_op(input logic dir);
      return (dir == SCAN_FWD) ? CBF : CBB;
   endfunction

   // Bracket that closes one nesting level in the given scan direction.
   function automatic op_code close_op(input logic dir);
      return (dir == SCAN_FWD) ? CBB : CBF;
   endfunction

endpackage

// File: rtl/branch_scanner_nest_counter.sv
// ---------------------------------------------------------------------------
// nest_counter
//   Nesting-depth up/down counter for the bracket scanner.
//   Ports:
//     clock, reset  rising-edge clock, asynchronous active-high reset
//     load          force count to 1 (the bracket that launched the scan)
//     inc, dec      one-step up/down request (mutually exclusive in use)
//     count         current depth
//     zero_next     this cycle's dec takes the depth to zero
//     overflow      this cycle's inc would pass the maximum depth
// ---------------------------------------------------------------------------
module nest_counter
   import branch_scanner_pkg::*;
#(
   parameter int unsigned DEPTH_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               inc,
   input  logic               dec,
   output logic [DEPTH_W-1:0] count,
   output logic               zero_next,
   output logic               overflow
);

   localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

   assign overflow  = inc & ~dec & (count == '1);
   assign zero_next = dec & ~inc & (count == ONE);

   // An overflowing increment leaves the count untouched; the scanner
   // aborts on the same edge, so the held value is never used.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= ONE;
      end else if (inc && !dec && !overflow) begin
         count <= count + ONE;
      end else if (dec && !inc) begin
         count <= count - ONE;
      end
   end

endmodule

// File: rtl/branch_scanner.sv
// ---------------------------------------------------------------------------
// branch_scanner
//   Bracket-matching engine for CBF/CBB. It walks instruction memory forward
//   (CBF) or backward (CBB) from the branching bracket and tracks the nesting
//   depth. When the matching bracket is found it returns the resume PC.
//   Ports:
//     clock, reset  rising-edge clock, asynchronous active-high reset
//     start         one-cycle scan request, accepted in IDLE only
//     direction     SCAN_FWD / SCAN_BACK, sampled with start
//     start_pc      address of the branching bracket, sampled with start
//     imem_req      fetch request, held with imem_addr until imem_valid
//     imem_addr     address being fetched
//     imem_valid    imem_data valid (may coincide with the request)
//     imem_data     instruction at imem_addr
//     busy          scan in progress, through the DONE/ERROR cycle
//     done          one-cycle pulse, target_pc valid
//     target_pc     matching bracket address + 1
//     error         sticky: unmatched bracket or depth overflow
// ---------------------------------------------------------------------------
module branch_scanner
   import branch_scanner_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DEPTH_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              direction,
   input  logic [ADDR_W-1:0] start_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  op_code            imem_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] target_pc,
   output logic              error
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   scan_state_e        state;
   logic               dir_q;
   logic [DEPTH_W-1:0] depth;
   logic               cnt_load;
   logic               cnt_inc;
   logic               cnt_dec;
   logic               cnt_zero_next;
   logic               cnt_overflow;
   logic               fetch_hit;
   logic               start_blocked;
   logic               at_edge;
   logic [ADDR_W-1:0]  addr_step;

   // A fetch is consumed only while the request is actually up.
   assign fetch_hit = (state == SCAN_FETCH) & imem_req & imem_valid;
   assign cnt_load  = (state == SCAN_IDLE) & start;
   assign cnt_inc   = fetch_hit & (imem_data == open_op(dir_q));
   assign cnt_dec   = fetch_hit & (imem_data == close_op(dir_q));

   // The first step away from the bracket would already wrap.
   assign start_blocked = (direction == SCAN_FWD) ? (start_pc == '1) : (start_pc == '0);
   // The current fetch sits on the last address reachable in this direction.
   assign at_edge       = (dir_q == SCAN_FWD) ? (imem_addr == '1) : (imem_addr == '0);
   assign addr_step     = (dir_q == SCAN_FWD) ? (imem_addr + ADDR_ONE) : (imem_addr - ADDR_ONE);

   nest_counter #(
      .DEPTH_W (DEPTH_W)
   ) u_depth (
      .clock     (clock),
      .reset     (reset),
      .load      (cnt_load),
      .inc       (cnt_inc),
      .dec       (cnt_dec),
      .count     (depth),
      .zero_next (cnt_zero_next),
      .overflow  (cnt_overflow)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= SCAN_IDLE;
         dir_q     <= SCAN_FWD;
         imem_req  <= DISABLE;
         imem_addr <= '0;
         busy      <= DISABLE;
         done      <= DISABLE;
         target_pc <= '0;
         error     <= DISABLE;
      end else begin
         done <= DISABLE;
         unique case (state)
            SCAN_IDLE: begin
               if (start) begin
                  dir_q <= direction;
                  busy  <= ENABLE;
                  if (start_blocked) begin
                     error <= ENABLE;
                     state <= SCAN_ERROR;
                  end else begin
                     error     <= DISABLE;
                     imem_req  <= ENABLE;
                     imem_addr <= (direction == SCAN_FWD) ? (start_pc + ADDR_ONE)
                                                          : (start_pc - ADDR_ONE);
                     state     <= SCAN_FETCH;
                  end
               end
            end

            SCAN_FETCH: begin
               // Overflow wins over a match; a match at the address edge is
               // legal, and only an unmatched edge fetch is an error.
               if (fetch_hit) begin
                  if (cnt_overflow) begin
                     imem_req <= DISABLE;
                     error    <= ENABLE;
                     state    <= SCAN_ERROR;
                  end else if (cnt_zero_next) begin
                     imem_req  <= DISABLE;
                     target_pc <= imem_addr + ADDR_ONE;
                     done      <= ENABLE;
                     state     <= SCAN_DONE;
                  end else if (at_edge) begin
                     imem_req <= DISABLE;
                     error    <= ENABLE;
                     state    <= SCAN_ERROR;
                  end else begin
                     imem_addr <= addr_step;
                  end
               end
            end

            SCAN_DONE: begin
               busy  <= DISABLE;
               state <= SCAN_IDLE;
            end

            SCAN_ERROR: begin
               busy  <= DISABLE;
               state <= SCAN_IDLE;
            end

            default: begin
               imem_req <= DISABLE;
               busy     <= DISABLE;
               state    <= SCAN_IDLE;
            end
         endcase
      end
   end

endmodule
